// File: rtl/score_bcd_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD score converter.
package score_bcd_converter_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned SCORE_W_DFLT  = 20;
  localparam int unsigned OUT_DIGITS    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StStore
  } state_e;

  typedef enum logic {
    ChScore,
    ChHigh
  } chan_e;

endpackage

// File: rtl/score_bcd_converter_add3_stage.sv
// Combinational double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
module score_bcd_converter_add3_stage
  import score_bcd_converter_pkg::*;
#(
  parameter int unsigned BCD_DIGITS = 7
) (
  input  logic [BCD_DIGITS*DIGIT_W-1:0] bcd_in,
  output logic [BCD_DIGITS*DIGIT_W-1:0] bcd_out
);

  always_comb begin
    bcd_out = bcd_in;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_in[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        bcd_out[i*DIGIT_W +: DIGIT_W] = bcd_in[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Shared sequential double-dabble converter for score and high_score display digits.
// Define BCD_SATURATE_EN to show 9999 on overflow instead of the value mod 10000.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int unsigned SCORE_W    = SCORE_W_DFLT,
  parameter int unsigned BCD_DIGITS = 7
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] high_score,
  output logic [3:0]         unit,
  output logic [3:0]         tens,
  output logic [3:0]         hundreds,
  output logic [3:0]         thousands,
  output logic [3:0]         h_unit,
  output logic [3:0]         h_tens,
  output logic [3:0]         h_hundreds,
  output logic [3:0]         h_thousands,
  output logic               busy,
  output logic               done,
  output logic               score_ovf,
  output logic               high_ovf
);

  localparam int unsigned BcdW = BCD_DIGITS * DIGIT_W;
  localparam int unsigned OutW = OUT_DIGITS * DIGIT_W;
  localparam int unsigned CntW = $clog2(SCORE_W + 1);

  state_e             state_q, state_d;
  chan_e              chan_q, chan_d, prio_q, prio_d, pick;
  logic [SCORE_W-1:0] bin_q, bin_d, oper_q, oper_d;
  logic [SCORE_W-1:0] last_score_q, last_score_d, last_high_q, last_high_d;
  logic [BcdW-1:0]    bcd_q, bcd_d, bcd_corr;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [OutW-1:0]    s_dig_q, s_dig_d, h_dig_q, h_dig_d, low_dig;
  logic               score_ovf_q, score_ovf_d, high_ovf_q, high_ovf_d;
  logic               done_q, done_d;
  logic               pend_s, pend_h, ovf;

  score_bcd_converter_add3_stage #(
    .BCD_DIGITS (BCD_DIGITS)
  ) u_add3 (
    .bcd_in  (bcd_q),
    .bcd_out (bcd_corr)
  );

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    prio_d       = prio_q;
    bin_d        = bin_q;
    oper_d       = oper_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    last_score_d = last_score_q;
    last_high_d  = last_high_q;
    s_dig_d      = s_dig_q;
    h_dig_d      = h_dig_q;
    score_ovf_d  = score_ovf_q;
    high_ovf_d   = high_ovf_q;
    done_d       = 1'b0;
    pend_s       = (score != last_score_q);
    pend_h       = (high_score != last_high_q);
    pick         = ChScore;
    ovf          = |bcd_q[BcdW-1:OutW];
    low_dig      = bcd_q[OutW-1:0];
`ifdef BCD_SATURATE_EN
    if (ovf) low_dig = {OUT_DIGITS{4'd9}};
`endif

    case (state_q)
      StIdle: begin
        if (pend_s || pend_h) begin
          if (pend_s && pend_h) pick = prio_q;
          else if (pend_s)      pick = ChScore;
          else                  pick = ChHigh;
          chan_d  = pick;
          bin_d   = (pick == ChScore) ? score : high_score;
          oper_d  = (pick == ChScore) ? score : high_score;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_corr[BcdW-2:0], bin_q[SCORE_W-1]};
        bin_d = {bin_q[SCORE_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(SCORE_W - 1)) state_d = StStore;
      end
      StStore: begin
        if (chan_q == ChScore) begin
          s_dig_d      = low_dig;
          score_ovf_d  = ovf;
          last_score_d = oper_q;
          prio_d       = ChHigh;
        end else begin
          h_dig_d      = low_dig;
          high_ovf_d   = ovf;
          last_high_d  = oper_q;
          prio_d       = ChScore;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      chan_q       <= ChScore;
      prio_q       <= ChScore;
      bin_q        <= '0;
      oper_q       <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      last_score_q <= '0;
      last_high_q  <= '0;
      s_dig_q      <= '0;
      h_dig_q      <= '0;
      score_ovf_q  <= 1'b0;
      high_ovf_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      prio_q       <= prio_d;
      bin_q        <= bin_d;
      oper_q       <= oper_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      last_score_q <= last_score_d;
      last_high_q  <= last_high_d;
      s_dig_q      <= s_dig_d;
      h_dig_q      <= h_dig_d;
      score_ovf_q  <= score_ovf_d;
      high_ovf_q   <= high_ovf_d;
      done_q       <= done_d;
    end
  end

  assign {thousands, hundreds, tens, unit}         = s_dig_q;
  assign {h_thousands, h_hundreds, h_tens, h_unit} = h_dig_q;
  assign score_ovf = score_ovf_q;
  assign high_ovf  = high_ovf_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter with a queue-based scoreboard of expected digit updates.
module tb_score_bcd_converter;

  typedef struct packed {
    logic        ch;    // 0 = score, 1 = high_score
    logic [15:0] dig;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] score, high_score;
  logic [3:0]  unit, tens, hundreds, thousands;
  logic [3:0]  h_unit, h_tens, h_hundreds, h_thousands;
  logic        busy, done, score_ovf, high_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t        sb_q[$];
  logic [15:0] exp_s, exp_h;
  logic        exp_sovf, exp_hovf;

  always #5 clk = ~clk;

  score_bcd_converter dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .score        (score),
    .high_score   (high_score),
    .unit         (unit),
    .tens         (tens),
    .hundreds     (hundreds),
    .thousands    (thousands),
    .h_unit       (h_unit),
    .h_tens       (h_tens),
    .h_hundreds   (h_hundreds),
    .h_thousands  (h_thousands),
    .busy         (busy),
    .done         (done),
    .score_ovf    (score_ovf),
    .high_ovf     (high_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion by division, independent of the shift-add datapath.
  function automatic exp_t model(input logic ch, input int unsigned v);
    int unsigned m;
    exp_t e;
    m = v % 10000;
`ifdef BCD_SATURATE_EN
    if (v > 9999) m = 9999;
`endif
    e.ch  = ch;
    e.ovf = (v > 9999);
    e.dig = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_sdig"}, 32'({thousands, hundreds, tens, unit}), 32'(exp_s));
    check({tag, "_sovf"}, 32'(score_ovf), 32'(exp_sovf));
    check({tag, "_hdig"}, 32'({h_thousands, h_hundreds, h_tens, h_unit}), 32'(exp_h));
    check({tag, "_hovf"}, 32'(high_ovf), 32'(exp_hovf));
  endtask

  task automatic clear_model();
    sb_q.delete();
    exp_s = '0; exp_h = '0; exp_sovf = 1'b0; exp_hovf = 1'b0;
  endtask

  // Waits for done, checks latency/busy, pops the scoreboard and checks both channels.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cycles = 0;
    int busy_lo = 0;
    bit seen = 0;
    exp_t e;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1;
      else if (!busy) busy_lo++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_cyc"}, 32'(cycles), 32'(exp_cycles));
      check({tag, "_busy_gap"}, 32'(busy_lo), 32'd0);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.ch) begin exp_h = e.dig; exp_hovf = e.ovf; end
        else      begin exp_s = e.dig; exp_sovf = e.ovf; end
      end
      check_outputs(tag);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dpulse;
    reset = 1'b0; score = '0; high_score = '0;
    clear_model();

    // 1: reset with zero inputs, no conversion afterwards
    repeat (3) @(negedge clk);
    check_outputs("rst");
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    dpulse = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) dpulse++;
    end
    check("idle_zero", 32'(dpulse), 32'd0);

    // 2: single conversion
    score = 20'd1234;
    sb_q.push_back(model(1'b0, 1234));
    wait_done("s1234", 22);

    // 3: both inputs change together after reset; score has priority
    reset = 1'b0; score = '0; high_score = '0;
    clear_model();
    @(negedge clk);
    check_outputs("rst2");
    reset = 1'b1;
    @(negedge clk);
    score = 20'd9999; high_score = 20'd10000;
    sb_q.push_back(model(1'b0, 9999));
    sb_q.push_back(model(1'b1, 10000));
    wait_done("both_s", 22);
    wait_done("both_h", 21);

    // 4: input changes mid-conversion, reconverted afterwards
    score = 20'd5;
    sb_q.push_back(model(1'b0, 5));
    repeat (10) @(negedge clk);
    score = 20'd6;
    sb_q.push_back(model(1'b0, 6));
    wait_done("mid5", 12);
    wait_done("mid6", 21);

    // 5: reset during SHIFT clears everything at once
    score = 20'd777;
    repeat (8) @(negedge clk);
    reset = 1'b0; high_score = '0;
    clear_model();
    #1;
    check_outputs("midrst");
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(model(1'b0, 777));
    wait_done("s777", 22);

    // 6: maximum input overflows the four displayed digits
    score = 20'hFFFFF;
    sb_q.push_back(model(1'b0, 1048575));
    wait_done("smax", 22);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
